shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, giving the data width, fixed at 8 to match the barrel_shifter datapath.
REQ-002 The module SHALL have parameter AMT_W, default 4, giving the shift-amount width, so amounts range 0..15.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port in_data, input, 8 bits: operand to shift.
REQ-006 The module SHALL have port in_amt, input, 4 bits: total logical shift amount, 0..15.
REQ-007 The module SHALL have port in_dir, input, 1 bit: 1 = left, 0 = right.
REQ-008 The module SHALL have port in_valid, input, 1 bit: request present.
REQ-009 The module SHALL have port in_ready, output, 1 bit: request can be accepted.
REQ-010 The module SHALL have port out_data, output, 8 bits: shifted result.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-012 The module SHALL have port out_ready, input, 1 bit: consumer takes the result.

Function
REQ-013 The FSM SHALL have three states, IDLE, SHIFT and DONE, and in_ready SHALL be 1 only in IDLE.
REQ-014 On an edge with in_valid=1 and in_ready=1, the block SHALL capture in_data into the data register, in_amt into the remaining register and in_dir into the direction register, then enter SHIFT.
REQ-015 In SHIFT, each cycle SHALL perform one pass: step = min(remaining, 7); data <= barrel_shifter(data, step, dir); remaining <= remaining - step.
REQ-016 The pass that leaves remaining = 0 SHALL move the FSM to DONE, so the pass count P = max(1, ceil(amt/7)): amounts 0..7 take P=1, 8..14 take P=2, and 15 takes P=3 (7+7+1).
REQ-017 in_amt = 0 SHALL still take one pass with step 0, and out_data SHALL equal in_data.
REQ-018 out_valid SHALL be asserted exactly P cycles after the accept edge and SHALL remain 1 in DONE until an edge with out_ready=1.
REQ-019 out_data SHALL be driven directly from the data register and SHALL be stable while out_valid=1.
REQ-020 On an edge in DONE with out_ready=1, the FSM SHALL return to IDLE.
REQ-021 A new request SHALL NOT be accepted on the same edge as the DONE-to-IDLE transition; the minimum request-to-request spacing is P+2 cycles.
REQ-022 The block SHALL ignore in_valid, in_data, in_amt and in_dir outside IDLE.
REQ-023 Vacated bits SHALL be zero in both directions, so any amount of 8 or more yields 8'h00 after the multi-pass sequence.
REQ-024 The remaining register SHALL never underflow, and step SHALL never exceed 7.

Reset
REQ-025 When rst_n=0, the block SHALL immediately, without waiting for a clock edge, force state=IDLE, data=0, remaining=0, dir=0, out_valid=0, in_ready=1 and out_data=8'h00.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation and discard any pending result.
REQ-027 The first request after rst_n deasserts SHALL be acceptable on the first rising edge.

Structure
REQ-028 The shared package shift_pkg SHALL hold the state enumeration (IDLE, SHIFT, DONE), the DATA_W and AMT_W defaults, and MAX_STEP=7.
REQ-029 The datapath SHALL instantiate exactly one barrel_shifter sub-module (in, shamt, dir, out), with no other shifting logic.
REQ-030 The step selection and remaining-count arithmetic SHALL be held in local combinational logic.

Verification
REQ-031 Scenario 1: in_data=8'hB1, in_amt=3, in_dir=1 -> out_data=8'h88, with out_valid 1 cycle after accept.
REQ-032 Scenario 2: in_data=8'hB1, in_amt=3, in_dir=0 -> out_data=8'h16 after 1 cycle; in_amt=0 -> out_data=8'hB1 after 1 cycle.
REQ-033 Scenario 3: in_data=8'hFF, in_amt=15, in_dir=0 -> out_data=8'h00, with out_valid exactly 3 cycles after accept and in_ready=0 throughout.
REQ-034 Scenario 4: hold out_ready=0 for 5 cycles after out_valid rises -> out_valid and out_data hold, and a new in_valid pulse is ignored; raising out_ready -> IDLE on the next edge.
REQ-035 Scenario 5: assert rst_n=0 during the 2nd pass of in_amt=14 -> outputs reach reset values immediately, and the next request completes correctly.
REQ-036 Scenario 6: back-to-back requests with out_ready tied to 1 -> accept edges are spaced exactly P+2 cycles apart.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the multi-pass shift sequencer: FSM states, default widths
// and the largest step the barrel shifter performs in one pass.
package shift_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_AMT_W  = 4;
  localparam int MAX_STEP   = 7;
  localparam int STEP_W     = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/barrel_shifter.sv
// Single-pass logical barrel shifter; vacated bits are zero in both directions.
module barrel_shifter
  import shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int SHAMT_W = STEP_W
) (
  input  logic [DATA_W-1:0]  in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               dir,
  output logic [DATA_W-1:0]  out
);

  always_comb begin
    if (dir) out = in << shamt;
    else     out = in >> shamt;
  end

endmodule

// File: rtl/shift_sequencer.sv
// Shifts an operand by 0..15 using a 7-bit-max barrel shifter over several passes,
// with a valid/ready request side and a valid/ready result side.
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int AMT_W  = DEF_AMT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_dir,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [AMT_W-1:0]    rem_q, rem_d;
  logic                dir_q, dir_d;
  logic [STEP_W-1:0]   step;
  logic [DATA_W-1:0]   shifted;

  barrel_shifter #(
    .DATA_W (DATA_W),
    .SHAMT_W(STEP_W)
  ) u_barrel (
    .in   (data_q),
    .shamt(step),
    .dir  (dir_q),
    .out  (shifted)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    // Clamp each pass to what the shifter can do; remaining never goes below zero.
    step = (rem_q > AMT_W'(MAX_STEP)) ? STEP_W'(MAX_STEP) : rem_q[STEP_W-1:0];
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          rem_d   = in_amt;
          dir_d   = in_dir;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        data_d = shifted;
        rem_d  = rem_q - AMT_W'(step);
        if (rem_q == AMT_W'(step)) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = data_q;

endmodule
